// File: rtl/gpp_run_monitor.sv
// gpp_run_monitor: run controller and observer for the GPP core.
// Sequences the GPP reset, counts RUN cycles and instruction fetches, and
// reports Done or timeout. It only observes the GPP / I-Cache bus.
// Optional feature macro: GPP_MON_TRACE_EN adds a circular trace of recent
// fetches (Addr plus the Data returned one cycle later). Without the macro
// there is no trace storage and the trace outputs read as zero.
module gpp_run_monitor #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [ADDR_W-1:0]              i_addr,
    input  logic [DATA_W-1:0]              i_data,
    input  logic                           i_rw,
    input  logic                           i_en,
    input  logic                           i_done,
    output logic                           o_gpp_rst,
    output logic                           o_running,
    output logic                           o_finished,
    output logic                           o_timed_out,
    output logic [CNT_W-1:0]               o_cycle_count,
    output logic [CNT_W-1:0]               o_fetch_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] i_trace_rd_idx,
    output logic [ADDR_W-1:0]              o_trace_addr,
    output logic [DATA_W-1:0]              o_trace_data,
    output logic [$clog2(TRACE_DEPTH):0]   o_trace_level
);

    localparam int IDX_W = $clog2(TRACE_DEPTH);
    localparam int LVL_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_clear;
    logic             w_in_run;
    logic             w_fetch;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_fetch;
    logic             r_gpp_rst;
    logic             r_running;
    logic             r_finished;
    logic             r_timed_out;

    // Next-state logic; Abort overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_state_nxt = ST_RESET;
            ST_RESET:   w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (i_done)
                    w_state_nxt = ST_DONE;
                else if (r_cycle == TO_LAST)
                    w_state_nxt = ST_TIMEOUT;
            end
            ST_DONE:    if (i_start) w_state_nxt = ST_RESET;
            ST_TIMEOUT: if (i_start) w_state_nxt = ST_RESET;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (i_abort)
            w_state_nxt = ST_IDLE;
    end

    assign w_clear  = (w_state_nxt == ST_RESET);
    assign w_in_run = (r_state == ST_RUN);
    assign w_fetch  = w_in_run && i_en && !i_rw;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Status flags registered from the next state so they track the FSM exactly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gpp_rst   <= 1'b1;
            r_running   <= 1'b0;
            r_finished  <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_gpp_rst   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RESET);
            r_running   <= (w_state_nxt == ST_RUN);
            r_finished  <= (w_state_nxt == ST_DONE);
            r_timed_out <= (w_state_nxt == ST_TIMEOUT);
        end
    end

    // Saturating cycle/fetch counters: cleared on entry to RESET, live only in RUN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle <= '0;
            r_fetch <= '0;
        end else if (w_clear) begin
            r_cycle <= '0;
            r_fetch <= '0;
        end else if (w_in_run) begin
            if (r_cycle != CNT_MAX)
                r_cycle <= r_cycle + 1'b1;
            if (w_fetch && (r_fetch != CNT_MAX))
                r_fetch <= r_fetch + 1'b1;
        end
    end

    assign o_gpp_rst     = r_gpp_rst;
    assign o_running     = r_running;
    assign o_finished    = r_finished;
    assign o_timed_out   = r_timed_out;
    assign o_cycle_count = r_cycle;
    assign o_fetch_count = r_fetch;

`ifdef GPP_MON_TRACE_EN
    logic [ADDR_W-1:0] r_tr_addr [TRACE_DEPTH];
    logic [DATA_W-1:0] r_tr_data [TRACE_DEPTH];
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              w_commit;
    logic [IDX_W-1:0]  w_base;
    logic [IDX_W-1:0]  w_rd_phys;
    logic              w_rd_valid;

    // A fetch's address is held one cycle until the I-Cache data arrives.
    // A commit landing on the RESET-entry edge is dropped: the trace restarts empty.
    assign w_commit = r_pend && !w_clear;

    // Trace bookkeeping: pending fetch, write pointer, saturating fill level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_wr_ptr    <= '0;
            r_level     <= '0;
        end else if (w_clear) begin
            r_pend   <= 1'b0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_pend <= w_fetch;
            if (w_fetch)
                r_pend_addr <= i_addr;
            if (r_pend) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_level != LVL_W'(TRACE_DEPTH))
                    r_level <= r_level + 1'b1;
            end
        end
    end

    // Entry storage; contents beyond the fill level are never exposed, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            r_tr_addr[r_wr_ptr] <= r_pend_addr;
            r_tr_data[r_wr_ptr] <= i_data;
        end
    end

    // Oldest entry sits 'level' slots behind the write pointer (wraps when full).
    assign w_base     = r_wr_ptr - r_level[IDX_W-1:0];
    assign w_rd_phys  = w_base + i_trace_rd_idx;
    assign w_rd_valid = ({1'b0, i_trace_rd_idx} < r_level);

    assign o_trace_addr  = w_rd_valid ? r_tr_addr[w_rd_phys] : '0;
    assign o_trace_data  = w_rd_valid ? r_tr_data[w_rd_phys] : '0;
    assign o_trace_level = r_level;
`else
    logic w_unused_trace;
    assign w_unused_trace = ^{i_trace_rd_idx, i_addr, i_data};

    assign o_trace_addr  = '0;
    assign o_trace_data  = '0;
    assign o_trace_level = '0;
`endif

endmodule
